cache_ctrl_fsm: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate cache controller that drives DataRam.

---
 rtl/cache_ctrl_fsm_if.sv | 38 +++
 rtl/cache_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_fsm_if.sv
// Bus bundle for cache_ctrl_fsm: processor port, main-memory port and DataRam port.
// The master modport is the cache controller; the slave modport is its surroundings
// (processor, memory and DataRam).
interface cache_ctrl_fsm_if #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8,
  parameter int DATA_W  = 16
);
  // Processor side
  logic [ADDR_W-1:0]  PAddr;
  logic [DATA_W-1:0]  PDataIn;
  logic               PRead;
  logic               PWrite;
  logic [DATA_W-1:0]  PDataOut;
  logic               PReady;
  // Main-memory side
  logic [ADDR_W-1:0]  MAddr;
  logic [DATA_W-1:0]  MDataOut;
  logic [DATA_W-1:0]  MDataIn;
  logic               MRead;
  logic               MWrite;
  logic               MReady;
  // DataRam side
  logic [INDEX_W-1:0] DAddress;
  logic [DATA_W-1:0]  DDataIn;
  logic [DATA_W-1:0]  DDataOut;
  logic               DWrite;

  modport master (
    input  PAddr, PDataIn, PRead, PWrite, MDataIn, MReady, DDataOut,
    output PDataOut, PReady, MAddr, MDataOut, MRead, MWrite, DAddress, DDataIn, DWrite
  );

  modport slave (
    output PAddr, PDataIn, PRead, PWrite, MDataIn, MReady, DDataOut,
    input  PDataOut, PReady, MAddr, MDataOut, MRead, MWrite, DAddress, DDataIn, DWrite
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Holds the tag/valid array and sequences lookups, read-miss line fills and
// write-through to main memory; the data words live in an external DataRam
// (one word per line, writes on negedge, registered read on posedge).
// Optional build macro CACHE_STATS_EN adds saturating read hit/miss counters
// on ports HitCount/MissCount.
module cache_ctrl_fsm #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8,
  parameter int DATA_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  cache_ctrl_fsm_if.master  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       HitCount,
  output logic [15:0]       MissCount
`endif
);

  localparam int TAG_W     = ADDR_W - INDEX_W;
  localparam int CACHESIZE = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    FILL,
    MEM_WR,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [DATA_W-1:0]      req_data_q, req_data_d;
  logic                   req_wr_q, req_wr_d;     // transaction is a write
  logic                   filled_q, filled_d;     // read went through FILL
  logic [CACHESIZE-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [CACHESIZE];
  logic                   tag_we;

  logic [INDEX_W-1:0]     idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;

  logic [DATA_W-1:0]      p_data_out;
  logic                   p_ready;
  logic [DATA_W-1:0]      m_data_out;
  logic                   m_read;
  logic                   m_write;
  logic [INDEX_W-1:0]     d_address;
  logic [DATA_W-1:0]      d_data_in;
  logic                   d_write;

  assign idx     = req_addr_q[INDEX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  // Next-state, request latching and Moore-style bus outputs
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_wr_d   = req_wr_q;
    filled_d   = filled_q;
    valid_d    = valid_q;
    tag_we     = 1'b0;
    p_data_out = '0;
    p_ready    = 1'b0;
    m_data_out = '0;
    m_read     = 1'b0;
    m_write    = 1'b0;
    d_address  = '0;
    d_data_in  = '0;
    d_write    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.PRead || bus.PWrite) begin
          req_addr_d = bus.PAddr;
          req_data_d = bus.PDataIn;
          // A simultaneous read and write request is served as a read.
          req_wr_d   = ~bus.PRead;
          filled_d   = 1'b0;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        // DataRam registers this address on the edge ending LOOKUP, so a read
        // hit finds its word on DDataOut during RESP.
        d_address = idx;
        if (!req_wr_q) begin
          state_d = hit ? RESP : MEM_RD;
        end else begin
          if (hit) begin
            d_write   = 1'b1;
            d_data_in = req_data_q;
          end
          state_d = MEM_WR;
        end
      end

      MEM_RD: begin
        m_read = 1'b1;
        if (bus.MReady) begin
          req_data_d = bus.MDataIn;
          state_d    = FILL;
        end
      end

      FILL: begin
        d_write      = 1'b1;
        d_address    = idx;
        d_data_in    = req_data_q;
        tag_we       = 1'b1;
        valid_d[idx] = 1'b1;
        filled_d     = 1'b1;
        state_d      = RESP;
      end

      MEM_WR: begin
        m_write    = 1'b1;
        m_data_out = req_data_q;
        if (bus.MReady) begin
          state_d = RESP;
        end
      end

      RESP: begin
        p_ready = 1'b1;
        if (req_wr_q) begin
          p_data_out = '0;
        end else if (filled_q) begin
          p_data_out = req_data_q;
        end else begin
          p_data_out = bus.DDataOut;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and valid registers; reset abandons any transaction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      filled_q   <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_wr_q   <= req_wr_d;
      filled_q   <= filled_d;
      valid_q    <= valid_d;
    end
  end

  // Tag storage; contents are only meaningful where the valid bit is set
  always_ff @(posedge Clk) begin
    if (tag_we) begin
      tag_q[idx] <= req_tag;
    end
  end

  assign bus.PDataOut = p_data_out;
  assign bus.PReady   = p_ready;
  assign bus.MAddr    = req_addr_q;
  assign bus.MDataOut = m_data_out;
  assign bus.MRead    = m_read;
  assign bus.MWrite   = m_write;
  assign bus.DAddress = d_address;
  assign bus.DDataIn  = d_data_in;
  assign bus.DWrite   = d_write;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count read lookups only; writes leave both counters alone
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP && !req_wr_q) begin
      if (hit) begin
        hit_cnt_d = sat_inc(hit_cnt_q);
      end else begin
        miss_cnt_d = sat_inc(miss_cnt_q);
      end
    end
  end

  // Statistics counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with a behavioural DataRam and a
// wait-state programmable memory responder.
module tb_cache_ctrl_fsm;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  cache_ctrl_fsm_if #(.ADDR_W(16), .INDEX_W(8), .DATA_W(16)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_ctrl_fsm #(.ADDR_W(16), .INDEX_W(8), .DATA_W(16)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus)
`ifdef CACHE_STATS_EN
    ,
    .HitCount (hit_count),
    .MissCount(miss_count)
`endif
  );

  // DataRam model: write on negedge, registered read on posedge
  logic [15:0] dram [256];

  always @(negedge Clk) begin
    if (bus.DWrite) dram[bus.DAddress] <= bus.DDataIn;
  end

  always @(posedge Clk) begin
    bus.DDataOut <= dram[bus.DAddress];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observations from the last transaction
  int          o_cyc, o_mrd, o_mwr, o_dwr, o_dw_cyc;
  logic [7:0]  o_dw_addr;
  logic [15:0] o_dw_data, o_mdo, o_pdo, o_maddr;

  // Issue one request at a negedge, serve memory with 'waits' wait cycles,
  // and record what the controller did until PReady; cycle 1 is LOOKUP.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input int waits, input logic [15:0] mdata);
    int   wcnt;
    logic done;
    o_cyc = 0; o_mrd = 0; o_mwr = 0; o_dwr = 0; o_dw_cyc = 0;
    o_dw_addr = '0; o_dw_data = '0; o_mdo = '0; o_pdo = '0; o_maddr = '0;
    wcnt = 0;
    done = 1'b0;
    bus.PAddr   = addr;
    bus.PDataIn = wdata;
    bus.PRead   = rd;
    bus.PWrite  = wr;
    bus.MDataIn = mdata;
    while (!done && o_cyc < 40) begin
      @(negedge Clk);
      o_cyc++;
      if (bus.DWrite) begin
        o_dwr++;
        if (o_dw_cyc == 0) o_dw_cyc = o_cyc;
        o_dw_addr = bus.DAddress;
        o_dw_data = bus.DDataIn;
      end
      if (bus.MWrite) begin
        o_mwr++;
        o_mdo = bus.MDataOut;
      end
      if (bus.MRead) begin
        o_mrd++;
        o_maddr = bus.MAddr;
      end
      if (bus.MRead || bus.MWrite) begin
        bus.MReady = (wcnt == waits);
        wcnt++;
      end else begin
        bus.MReady = 1'b0;
      end
      if (bus.PReady) begin
        o_pdo = bus.PDataOut;
        done  = 1'b1;
      end
    end
    chk("pready_seen", {31'd0, done}, 32'd1);
    bus.PRead   = 1'b0;
    bus.PWrite  = 1'b0;
    bus.MReady  = 1'b0;
    bus.MDataIn = '0;
    @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dram[i] = '0;
    Reset        = 1'b1;
    bus.PAddr    = '0;
    bus.PDataIn  = '0;
    bus.PRead    = 1'b0;
    bus.PWrite   = 1'b0;
    bus.MDataIn  = '0;
    bus.MReady   = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_preready", {31'd0, bus.PReady}, 32'd0);
    chk("rst_mread",    {31'd0, bus.MRead},  32'd0);
    chk("rst_mwrite",   {31'd0, bus.MWrite}, 32'd0);
    chk("rst_dwrite",   {31'd0, bus.DWrite}, 32'd0);
    chk("rst_buses",    {bus.PDataOut, bus.MAddr}, 32'd0);
    chk("rst_dbus",     {bus.MDataOut, 8'd0, bus.DAddress}, 32'd0);
    chk("rst_ddatain",  {16'd0, bus.DDataIn}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Read miss with two memory waits, line fill at index 05
    txn(1'b1, 1'b0, 16'h0105, 16'h0000, 2, 16'hBEEF);
    chk("miss1_mread_cycles", o_mrd, 3);
    chk("miss1_maddr",        {16'd0, o_maddr}, 32'h0105);
    chk("miss1_dwrite_cycles", o_dwr, 1);
    chk("miss1_fill_idx",     {24'd0, o_dw_addr}, 32'h05);
    chk("miss1_fill_data",    {16'd0, o_dw_data}, 32'hBEEF);
    chk("miss1_pdata",        {16'd0, o_pdo}, 32'hBEEF);
    chk("miss1_latency",      o_cyc, 6);

    // Read hit on the same address
    txn(1'b1, 1'b0, 16'h0105, 16'h0000, 0, 16'h0000);
    chk("hit1_mread",   o_mrd, 0);
    chk("hit1_latency", o_cyc, 2);
    chk("hit1_pdata",   {16'd0, o_pdo}, 32'hBEEF);

    // Write hit: DataRam updated in LOOKUP, then write-through
    txn(1'b0, 1'b1, 16'h0105, 16'h1234, 0, 16'h0000);
    chk("wrhit_dwrite_cycles", o_dwr, 1);
    chk("wrhit_dwrite_in_lookup", o_dw_cyc, 1);
    chk("wrhit_ddatain",  {16'd0, o_dw_data}, 32'h1234);
    chk("wrhit_mwrite",   o_mwr, 1);
    chk("wrhit_mdataout", {16'd0, o_mdo}, 32'h1234);
    chk("wrhit_pdata",    {16'd0, o_pdo}, 32'h0);
    chk("wrhit_latency",  o_cyc, 3);

    txn(1'b1, 1'b0, 16'h0105, 16'h0000, 0, 16'h0000);
    chk("hit2_mread", o_mrd, 0);
    chk("hit2_pdata", {16'd0, o_pdo}, 32'h1234);

    // Write miss: no allocation, one wait cycle on memory
    txn(1'b0, 1'b1, 16'h0206, 16'h5555, 1, 16'h0000);
    chk("wrmiss_dwrite",   o_dwr, 0);
    chk("wrmiss_mwrite",   o_mwr, 2);
    chk("wrmiss_mdataout", {16'd0, o_mdo}, 32'h5555);
    chk("wrmiss_latency",  o_cyc, 4);

    txn(1'b1, 1'b0, 16'h0206, 16'h0000, 0, 16'h5555);
    chk("miss2_mread",   o_mrd, 1);
    chk("miss2_pdata",   {16'd0, o_pdo}, 32'h5555);
    chk("miss2_latency", o_cyc, 4);

    // Read and write together: served as a read hit, write ignored
    txn(1'b1, 1'b1, 16'h0206, 16'h9999, 0, 16'h0000);
    chk("both_mwrite", o_mwr, 0);
    chk("both_dwrite", o_dwr, 0);
    chk("both_pdata",  {16'd0, o_pdo}, 32'h5555);

    // Alias at index 05 with a new tag evicts 0105
    txn(1'b1, 1'b0, 16'h0305, 16'h0000, 0, 16'h7777);
    chk("alias_mread",    o_mrd, 1);
    chk("alias_fill_idx", {24'd0, o_dw_addr}, 32'h05);
    chk("alias_pdata",    {16'd0, o_pdo}, 32'h7777);

    txn(1'b1, 1'b0, 16'h0105, 16'h0000, 1, 16'h1234);
    chk("evicted_mread", o_mrd, 2);
    chk("evicted_pdata", {16'd0, o_pdo}, 32'h1234);

`ifdef CACHE_STATS_EN
    chk("stats_hits",   {16'd0, hit_count},  32'd3);
    chk("stats_misses", {16'd0, miss_count}, 32'd4);
`endif

    // Reset while waiting in MEM_RD
    bus.PAddr = 16'h0405;
    bus.PRead = 1'b1;
    for (int i = 0; i < 10 && !bus.MRead; i++) @(negedge Clk);
    chk("rstmid_mread_before", {31'd0, bus.MRead}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("rstmid_mread_drop", {31'd0, bus.MRead}, 32'd0);
    chk("rstmid_maddr",      {16'd0, bus.MAddr}, 32'd0);
    @(negedge Clk);
    bus.PRead = 1'b0;
    Reset     = 1'b0;
    bus.MDataIn = 16'hDEAD;
    bus.MReady  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("late_mready_quiet",
          {29'd0, bus.MRead, bus.PReady, bus.DWrite}, 32'd0);
    end
    bus.MReady  = 1'b0;
    bus.MDataIn = '0;
`ifdef CACHE_STATS_EN
    chk("stats_hits_rst",   {16'd0, hit_count},  32'd0);
    chk("stats_misses_rst", {16'd0, miss_count}, 32'd0);
`endif

    // Valid bits cleared: 0105 misses again
    txn(1'b1, 1'b0, 16'h0105, 16'h0000, 0, 16'hABCD);
    chk("postrst_mread", o_mrd, 1);
    chk("postrst_pdata", {16'd0, o_pdo}, 32'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
